// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the parametrised BCD stopwatch counter.
// Holds the control-state encoding and the single-digit BCD increment helper.
package stopwatch_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_FULL  = 2'd3
    } state_t;

    // Out-of-range codes fold back to 0 so a corrupted digit self-heals.
    function automatic logic [DIGIT_W-1:0] bcd_next(input logic [DIGIT_W-1:0] d);
        bcd_next = (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the stopwatch chain: increments by one when enabled and
// rolls 9 -> 0, raising carry_out combinationally in the same cycle.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_en,
    output logic [DIGIT_W-1:0] o_digit,
    output logic               o_carry
);

    logic [DIGIT_W-1:0] r_digit;

    // Digit register: clear wins over increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_digit <= 4'd0;
        end else if (i_clear) begin
            r_digit <= 4'd0;
        end else if (i_en) begin
            r_digit <= bcd_next(r_digit);
        end else begin
            r_digit <= r_digit;
        end
    end

    assign o_digit = r_digit;
    assign o_carry = i_en && (r_digit >= BCD_MAX);

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch: prescaler plus a chain of BCD digits with start/stop/clear control.
// Define STOPWATCH_LAP_EN to build the lap capture register; otherwise lap is ignored.
module stopwatch_bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int TICK_HZ     = 10,
    parameter int INT_DIGITS  = 3,
    parameter int FRAC_DIGITS = 1,
    parameter int WRAP        = 1
)(
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic                                        stop,
    input  logic                                        clear,
    input  logic                                        lap,
    output logic                                        running,
    output logic                                        limite,
    output logic [DIGIT_W*(INT_DIGITS+FRAC_DIGITS)-1:0] count_bcd,
    output logic [DIGIT_W*(INT_DIGITS+FRAC_DIGITS)-1:0] lap_bcd,
    output logic                                        lap_valid
);

    localparam int               N_DIG    = INT_DIGITS + FRAC_DIGITS;
    localparam int               CNT_W    = DIGIT_W * N_DIG;
    localparam int               DIV      = CLK_HZ / TICK_HZ;
    localparam int               PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic             SAT      = (WRAP == 0);

    state_t             r_state;
    logic [PRE_W-1:0]   r_presc;
    logic               r_running;
    logic               r_limite;
    logic               w_tick;
    logic               w_full;
    logic               w_inc;
    logic [CNT_W-1:0]   w_count;
    logic [N_DIG-1:0]   w_en;
    logic [N_DIG-1:0]   w_carry;
    logic               w_unused_carry;

    assign w_tick         = (r_state == ST_RUN) && (r_presc == PRE_LAST);
    // In saturating mode a tick at all-nines must leave the digits untouched.
    assign w_inc          = w_tick && !(w_full && SAT);
    assign w_unused_carry = w_carry[N_DIG-1];

    // Full scale: every digit reads 9.
    always_comb begin
        w_full = 1'b1;
        for (int i = 0; i < N_DIG; i++) begin
            if (w_count[i*DIGIT_W +: DIGIT_W] != BCD_MAX) begin
                w_full = 1'b0;
            end else begin
                w_full = w_full;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_DIG; g++) begin : g_digit
            if (g == 0) begin : g_lsd
                assign w_en[g] = w_inc;
            end else begin : g_upper
                assign w_en[g] = w_carry[g-1];
            end
            bcd_digit u_digit (
                .i_clk   (clk),
                .i_rst_n (reset),
                .i_clear (clear),
                .i_en    (w_en[g]),
                .o_digit (w_count[g*DIGIT_W +: DIGIT_W]),
                .o_carry (w_carry[g])
            );
        end
    endgenerate

    // Control FSM with prescaler and registered running/limite.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_limite  <= 1'b0;
        end else if (clear) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_limite  <= 1'b0;
        end else begin
            if (!SAT) begin
                r_limite <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
                    if (w_tick && w_full) begin
                        r_limite <= 1'b1;
                    end
                    if (w_tick && w_full && SAT) begin
                        r_state   <= ST_FULL;
                        r_running <= 1'b0;
                    end else if (stop) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (start && !stop) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_FULL: begin
                    r_state <= ST_FULL;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_presc   <= '0;
                    r_running <= 1'b0;
                    r_limite  <= 1'b0;
                end
            endcase
        end
    end

    assign running   = r_running;
    assign limite    = r_limite;
    assign count_bcd = w_count;

`ifdef STOPWATCH_LAP_EN
    logic [CNT_W-1:0] r_lap_bcd;
    logic             r_lap_valid;

    // Lap capture takes the pre-increment count of the sampling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lap_bcd   <= '0;
            r_lap_valid <= 1'b0;
        end else if (clear) begin
            r_lap_bcd   <= '0;
            r_lap_valid <= 1'b0;
        end else if (lap && ((r_state == ST_RUN) || (r_state == ST_PAUSE))) begin
            r_lap_bcd   <= w_count;
            r_lap_valid <= 1'b1;
        end else begin
            r_lap_bcd   <= r_lap_bcd;
            r_lap_valid <= r_lap_valid;
        end
    end

    assign lap_bcd   = r_lap_bcd;
    assign lap_valid = r_lap_valid;
`else
    logic w_unused_lap;

    assign w_unused_lap = lap;
    assign lap_bcd      = '0;
    assign lap_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench: DIV=10, two integer + one fractional digit, wrapping and saturating copies.
module tb_stopwatch_bcd_counter;

    logic        clk = 1'b0;
    logic        reset, start, stop, clear, lap;
    logic        run_w, lim_w, lv_w, run_s, lim_s, lv_s;
    logic [11:0] cnt_w, lap_w, cnt_s, lap_s;
    logic [11:0] exp_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    stopwatch_bcd_counter #(.CLK_HZ(100), .TICK_HZ(10), .INT_DIGITS(2), .FRAC_DIGITS(1), .WRAP(1)) dut_wrap (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .running(run_w), .limite(lim_w), .count_bcd(cnt_w), .lap_bcd(lap_w), .lap_valid(lv_w));

    stopwatch_bcd_counter #(.CLK_HZ(100), .TICK_HZ(10), .INT_DIGITS(2), .FRAC_DIGITS(1), .WRAP(0)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .running(run_s), .limite(lim_s), .count_bcd(cnt_s), .lap_bcd(lap_s), .lap_valid(lv_s));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(1); stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(1); clear = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1; step(1); lap = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
        step(2);
        n_checks++; if ({cnt_w, cnt_s} !== 24'h0) begin n_fail++; $display("FAIL reset_cnt got=%h/%h exp=0", cnt_w, cnt_s); end
        n_checks++; if ({run_w, run_s, lim_w, lim_s} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {run_w, run_s, lim_w, lim_s}); end
        n_checks++; if ({lap_w, lv_w, lap_s, lv_s} !== 26'h0) begin n_fail++; $display("FAIL reset_lap got=%h/%b exp=0", lap_w, lv_w); end
        reset = 1'b1;
        step(3);
        n_checks++; if ({cnt_w, run_w} !== 13'h0) begin n_fail++; $display("FAIL idle_hold got=%h run=%b exp=0", cnt_w, run_w); end
    endtask

    task automatic test_first_tick();
        pulse_start();
        n_checks++; if (run_w !== 1'b1) begin n_fail++; $display("FAIL start_running got=%b exp=1", run_w); end
        for (int k = 1; k <= 10; k++) begin
            step(1);
            exp_cnt = (k == 10) ? 12'h001 : 12'h000;
            n_checks++; if (cnt_w !== exp_cnt) begin n_fail++; $display("FAIL first_tick_edge%0d got=%h exp=%h", k, cnt_w, exp_cnt); end
            n_checks++; if (run_w !== 1'b1) begin n_fail++; $display("FAIL first_tick_run%0d got=%b exp=1", k, run_w); end
        end
    endtask

    task automatic test_carry();
        step(980);
        n_checks++; if (cnt_w !== 12'h099) begin n_fail++; $display("FAIL carry_pre got=%h exp=099", cnt_w); end
        step(9);
        n_checks++; if (cnt_w !== 12'h099) begin n_fail++; $display("FAIL carry_hold got=%h exp=099", cnt_w); end
        step(1);
        n_checks++; if (cnt_w !== 12'h100) begin n_fail++; $display("FAIL carry_two_digits got=%h exp=100", cnt_w); end
        n_checks++; if (cnt_s !== 12'h100) begin n_fail++; $display("FAIL carry_sat got=%h exp=100", cnt_s); end
    endtask

    task automatic test_full_scale();
        step(8990);
        n_checks++; if ({cnt_w, cnt_s} !== 24'h999999) begin n_fail++; $display("FAIL full_pre got=%h/%h exp=999", cnt_w, cnt_s); end
        n_checks++; if ({lim_w, lim_s} !== 2'b00) begin n_fail++; $display("FAIL full_pre_lim got=%b exp=00", {lim_w, lim_s}); end
        step(10);
        n_checks++; if (cnt_w !== 12'h000) begin n_fail++; $display("FAIL wrap_cnt got=%h exp=000", cnt_w); end
        n_checks++; if ({lim_w, run_w} !== 2'b11) begin n_fail++; $display("FAIL wrap_lim_run got=%b exp=11", {lim_w, run_w}); end
        n_checks++; if (cnt_s !== 12'h999) begin n_fail++; $display("FAIL sat_cnt got=%h exp=999", cnt_s); end
        n_checks++; if ({lim_s, run_s} !== 2'b10) begin n_fail++; $display("FAIL sat_lim_run got=%b exp=10", {lim_s, run_s}); end
        step(1);
        n_checks++; if ({lim_w, run_w} !== 2'b01) begin n_fail++; $display("FAIL wrap_lim_pulse got=%b exp=01", {lim_w, run_w}); end
        n_checks++; if ({cnt_s, lim_s} !== 13'h1333) begin n_fail++; $display("FAIL sat_hold got=%h lim=%b exp=999/1", cnt_s, lim_s); end
        pulse_start();
        step(12);
        n_checks++; if ({cnt_s, lim_s, run_s} !== 14'h2666) begin n_fail++; $display("FAIL sat_ignore_start got=%h %b%b exp=999 10", cnt_s, lim_s, run_s); end
        pulse_clear();
        n_checks++; if ({cnt_s, lim_s, run_s} !== 14'h0) begin n_fail++; $display("FAIL sat_clear got=%h %b%b exp=000 00", cnt_s, lim_s, run_s); end
        n_checks++; if ({cnt_w, lim_w, run_w} !== 14'h0) begin n_fail++; $display("FAIL wrap_clear got=%h %b%b exp=000 00", cnt_w, lim_w, run_w); end
    endtask

    task automatic test_pause_resume();
        pulse_start();
        step(14);
        n_checks++; if (cnt_w !== 12'h001) begin n_fail++; $display("FAIL pause_pre got=%h exp=001", cnt_w); end
        pulse_stop();
        n_checks++; if ({cnt_w, run_w} !== {12'h001, 1'b0}) begin n_fail++; $display("FAIL pause_enter got=%h run=%b exp=001/0", cnt_w, run_w); end
        step(20);
        n_checks++; if ({cnt_w, run_w} !== {12'h001, 1'b0}) begin n_fail++; $display("FAIL pause_hold got=%h run=%b exp=001/0", cnt_w, run_w); end
        pulse_start();
        n_checks++; if (run_w !== 1'b1) begin n_fail++; $display("FAIL resume_run got=%b exp=1", run_w); end
        step(4);
        n_checks++; if (cnt_w !== 12'h001) begin n_fail++; $display("FAIL resume_early got=%h exp=001", cnt_w); end
        step(1);
        n_checks++; if (cnt_w !== 12'h002) begin n_fail++; $display("FAIL resume_phase got=%h exp=002", cnt_w); end
        start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
        n_checks++; if ({run_w, run_s} !== 2'b00) begin n_fail++; $display("FAIL start_stop_same got=%b exp=00", {run_w, run_s}); end
    endtask

    task automatic test_stop_on_tick();
        pulse_start();
        step(8);
        n_checks++; if (cnt_w !== 12'h002) begin n_fail++; $display("FAIL stop_tick_pre got=%h exp=002", cnt_w); end
        pulse_stop();
        n_checks++; if ({cnt_w, run_w} !== {12'h003, 1'b0}) begin n_fail++; $display("FAIL stop_tick got=%h run=%b exp=003/0", cnt_w, run_w); end
        step(15);
        n_checks++; if (cnt_w !== 12'h003) begin n_fail++; $display("FAIL stop_tick_hold got=%h exp=003", cnt_w); end
        pulse_clear();
    endtask

    task automatic test_lap();
        pulse_start();
        step(230);
        n_checks++; if (cnt_w !== 12'h023) begin n_fail++; $display("FAIL lap_pre got=%h exp=023", cnt_w); end
        pulse_lap();
`ifdef STOPWATCH_LAP_EN
        n_checks++; if ({lap_w, lv_w} !== {12'h023, 1'b1}) begin n_fail++; $display("FAIL lap_capture got=%h/%b exp=023/1", lap_w, lv_w); end
`else
        n_checks++; if ({lap_w, lv_w} !== 13'h0) begin n_fail++; $display("FAIL lap_disabled got=%h/%b exp=000/0", lap_w, lv_w); end
`endif
        n_checks++; if (run_w !== 1'b1) begin n_fail++; $display("FAIL lap_keeps_run got=%b exp=1", run_w); end
        step(9);
        n_checks++; if (cnt_w !== 12'h024) begin n_fail++; $display("FAIL lap_continue got=%h exp=024", cnt_w); end
`ifdef STOPWATCH_LAP_EN
        n_checks++; if (lap_w !== 12'h023) begin n_fail++; $display("FAIL lap_stable got=%h exp=023", lap_w); end
`endif
        pulse_clear();
        n_checks++; if ({lap_w, lv_w, cnt_w} !== 25'h0) begin n_fail++; $display("FAIL lap_clear got=%h/%b cnt=%h exp=0", lap_w, lv_w, cnt_w); end
        pulse_lap();
        n_checks++; if (lv_w !== 1'b0) begin n_fail++; $display("FAIL lap_idle_ignored got=%b exp=0", lv_w); end
    endtask

    task automatic test_async_reset();
        pulse_start();
        step(25);
        n_checks++; if (cnt_w !== 12'h002) begin n_fail++; $display("FAIL async_pre got=%h exp=002", cnt_w); end
        pulse_lap();
        #3 reset = 1'b0;
        #1;
        n_checks++; if ({cnt_w, run_w, lim_w, lap_w, lv_w} !== 27'h0) begin n_fail++; $display("FAIL async_reset got=%h %b%b %h%b exp=0", cnt_w, run_w, lim_w, lap_w, lv_w); end
        n_checks++; if ({cnt_s, run_s, lim_s, lap_s, lv_s} !== 27'h0) begin n_fail++; $display("FAIL async_reset_sat got=%h %b%b exp=0", cnt_s, run_s, lim_s); end
        step(1);
        reset = 1'b1;
        step(3);
        n_checks++; if ({cnt_w, run_w} !== 13'h0) begin n_fail++; $display("FAIL post_reset got=%h run=%b exp=0", cnt_w, run_w); end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_carry();
        test_full_scale();
        test_pause_resume();
        test_stop_on_tick();
        test_lap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
